// File: rtl/mem_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_unit_pkg
// Description : Shared state encoding and default widths for mem_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_unit_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 13;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spram_sync.sv
`default_nettype none
// ============================================================================
// Module      : spram_sync
// Description : Single-port synchronous RAM, write-first, registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_sync #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // No reset on the array or output so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
            r_rdata     <= wdata;
        end else begin
            r_rdata     <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_unit
// Description : A/D registers plus block-RAM data memory M[A] with handshake,
//               post-reset clear sweep and out-of-range address fault.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              reg_a_en,
    input  logic              reg_d_en,
    input  logic              reg_m_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic [DATA_W-1:0] reg_a_out,
    output logic [DATA_W-1:0] reg_d_out,
    output logic [DATA_W-1:0] reg_m_out,
    output logic              m_valid,
    output logic              addr_fault
);

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic [DATA_W-1:0]  r_reg_a;
    logic [DATA_W-1:0]  r_reg_d;
    logic               w_idle;
    logic               w_accept;
    logic               w_fault;
    logic               w_ram_we;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [DATA_W-1:0]  w_ram_wdata;
    logic [DATA_W-1:0]  w_ram_q;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = req && w_idle;

    generate
        if (ADDR_W < DATA_W) begin : g_fault
            assign w_fault = |r_reg_a[DATA_W-1:ADDR_W];
        end else begin : g_no_fault
            assign w_fault = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_reg_a   <= '0;
            r_reg_d   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
            if (w_accept && reg_a_en) begin
                r_reg_a <= data_in;
            end
            if (w_accept && reg_d_en) begin
                r_reg_d <= data_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == c_last_addr) w_state_nxt = ST_WAIT;
            ST_IDLE:  if (w_accept && (reg_a_en || reg_m_en)) w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // The write address is the pre-access A; WAIT then reads the new A.
    always_comb begin
        w_ram_we    = w_accept && reg_m_en && !w_fault;
        w_ram_addr  = r_reg_a[ADDR_W-1:0];
        w_ram_wdata = data_in;
        if (r_state == ST_CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_clr_cnt;
            w_ram_wdata = '0;
        end
    end

    spram_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_q)
    );

    assign ready      = w_idle;
    assign m_valid    = w_idle;
    assign reg_a_out  = r_reg_a;
    assign reg_d_out  = r_reg_d;
    assign addr_fault = w_fault;
    // RAM output cannot be reset, so it is masked until the read is valid.
    assign reg_m_out  = (w_idle && !w_fault) ? w_ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_unit
// Description : Self-checking bench for mem_unit with DATA_W=16, ADDR_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_unit;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic        reg_a_en;
    logic        reg_d_en;
    logic        reg_m_en;
    logic [15:0] data_in;
    logic        ready;
    logic [15:0] reg_a_out;
    logic [15:0] reg_d_out;
    logic [15:0] reg_m_out;
    logic        m_valid;
    logic        addr_fault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        a;
        logic        d;
        logic        m;
        logic [15:0] data;
        logic [15:0] exp_a;
        logic [15:0] exp_d;
        logic [15:0] exp_m;
    } vec_t;

    vec_t vecs [10];

    mem_unit #(
        .DATA_W (16),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .reg_a_en   (reg_a_en),
        .reg_d_en   (reg_d_en),
        .reg_m_en   (reg_m_en),
        .data_in    (data_in),
        .ready      (ready),
        .reg_a_out  (reg_a_out),
        .reg_d_out  (reg_d_out),
        .reg_m_out  (reg_m_out),
        .m_valid    (m_valid),
        .addr_fault (addr_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one access, waits for acceptance and the read-back window.
    task automatic do_acc(input logic a, input logic d, input logic m, input logic [15:0] data);
        int n;
        n = 0;
        req = 1'b1; reg_a_en = a; reg_d_en = d; reg_m_en = m; data_in = data;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("acc_timeout", ready, 1);
        tick();
        req = 1'b0; reg_a_en = 1'b0; reg_d_en = 1'b0; reg_m_en = 1'b0;
        if (a || m) begin
            chk("dip_valid", m_valid, 0);
            chk("dip_ready", ready, 0);
            tick();
        end
        chk("valid_after", m_valid, 1);
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0005, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0006, 16'h0006, 16'h0000, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0009, 16'h0009, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h0000, 16'h0009};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h0003, 16'h1234, 16'h0009};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 16'h000A, 16'h000A, 16'h000A, 16'h0000};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0003, 16'h000A, 16'h000A};

        reset_n = 1'b0; req = 1'b0; reg_a_en = 1'b0; reg_d_en = 1'b0;
        reg_m_en = 1'b0; data_in = '0;
        #12;
        chk("rst_ready", ready, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_a", reg_a_out, 0);
        chk("rst_d", reg_d_out, 0);
        chk("rst_m", reg_m_out, 0);
        chk("rst_fault", addr_fault, 0);

        @(negedge clk);
        reset_n = 1'b1;
        wait_ready("clear_cycles", 17);
        chk("clear_valid", m_valid, 1);
        chk("clear_m0", reg_m_out, 0);

        for (int i = 0; i < 16; i++) begin
            do_acc(1'b1, 1'b0, 1'b0, 16'(i));
            chk("clear_read", reg_m_out, 0);
        end

        for (int i = 0; i < 10; i++) begin
            do_acc(vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].data);
            chk($sformatf("vec%0d_a", i), reg_a_out, vecs[i].exp_a);
            chk($sformatf("vec%0d_d", i), reg_d_out, vecs[i].exp_d);
            chk($sformatf("vec%0d_m", i), reg_m_out, vecs[i].exp_m);
        end

        // Back-to-back D-only accesses never drop ready.
        req = 1'b1; reg_d_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in = 16'(i);
            chk("dburst_ready", ready, 1);
            tick();
        end
        req = 1'b0; reg_d_en = 1'b0;
        chk("dburst_d", reg_d_out, 4);
        chk("dburst_valid", m_valid, 1);

        // Request raised during WAIT is taken one cycle later.
        req = 1'b1; reg_a_en = 1'b1; data_in = 16'h0005;
        tick();
        reg_a_en = 1'b0; reg_d_en = 1'b1; data_in = 16'h0055;
        chk("wreq_wait_ready", ready, 0);
        chk("wreq_wait_d", reg_d_out, 4);
        tick();
        chk("wreq_idle_ready", ready, 1);
        chk("wreq_idle_d", reg_d_out, 4);
        tick();
        req = 1'b0; reg_d_en = 1'b0;
        chk("wreq_taken_d", reg_d_out, 16'h0055);
        chk("wreq_m5", reg_m_out, 16'hBEEF);

        // Out-of-range A suppresses writes and masks the read.
        do_acc(1'b1, 1'b0, 1'b0, 16'h0012);
        chk("flt_set", addr_fault, 1);
        chk("flt_a", reg_a_out, 16'h0012);
        chk("flt_m", reg_m_out, 0);
        do_acc(1'b0, 1'b0, 1'b1, 16'h0007);
        chk("flt_wr_fault", addr_fault, 1);
        chk("flt_wr_m", reg_m_out, 0);
        do_acc(1'b1, 1'b0, 1'b0, 16'h0002);
        chk("flt_clr", addr_fault, 0);
        chk("flt_m2", reg_m_out, 0);

        do_acc(1'b1, 1'b0, 1'b0, 16'h0007);
        do_acc(1'b0, 1'b0, 1'b1, 16'h0077);
        chk("m7_written", reg_m_out, 16'h0077);

        // Reset during WAIT.
        req = 1'b1; reg_a_en = 1'b1; reg_d_en = 1'b1; data_in = 16'h0013;
        tick();
        req = 1'b0; reg_a_en = 1'b0; reg_d_en = 1'b0;
        chk("pre_rst_wait", ready, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("wrst_a", reg_a_out, 0);
        chk("wrst_d", reg_d_out, 0);
        chk("wrst_fault", addr_fault, 0);
        chk("wrst_ready", ready, 0);
        chk("wrst_valid", m_valid, 0);
        chk("wrst_m", reg_m_out, 0);

        // Reset mid-CLEAR with the counter at 8.
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("crst_ready", ready, 0);
        chk("crst_valid", m_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready("reclear_cycles", 17);
        chk("reclear_m0", reg_m_out, 0);
        do_acc(1'b1, 1'b0, 1'b0, 16'h0007);
        chk("reclear_m7", reg_m_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
